// File: rtl/easyaxi_rd_arb_if.sv
// easyaxi_rd_arb_if: one AXI read channel (AR + R) between a master and a slave.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif
`ifndef AXI_RESP_OKAY
`define AXI_RESP_OKAY 2'b00
`endif
`ifndef AXI_RESP_DECERR
`define AXI_RESP_DECERR 2'b11
`endif

interface easyaxi_rd_arb_if;
  logic                    arvalid;
  logic                    arready;
  logic [`AXI_ID_W-1:0]    arid;
  logic [`AXI_ADDR_W-1:0]  araddr;
  logic [`AXI_LEN_W-1:0]   arlen;
  logic [`AXI_SIZE_W-1:0]  arsize;
  logic [`AXI_BURST_W-1:0] arburst;
  logic                    rvalid;
  logic                    rready;
  logic [`AXI_DATA_W-1:0]  rdata;
  logic [`AXI_RESP_W-1:0]  rresp;
  logic                    rlast;
  modport master(output arvalid, arid, araddr, arlen, arsize, arburst, rready,
                 input arready, rvalid, rdata, rresp, rlast);
  modport slave(input arvalid, arid, araddr, arlen, arsize, arburst, rready,
                output arready, rvalid, rdata, rresp, rlast);
endinterface

// File: rtl/easyaxi_rd_arb.sv
// easyaxi_rd_arb: two-master AXI read arbiter, one outstanding transaction at the slave.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_rd_arb #(
  parameter int FIXED_PRI = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  easyaxi_rd_arb_if.slave         axi_mst0,
  easyaxi_rd_arb_if.slave         axi_mst1,
  easyaxi_rd_arb_if.master        axi_slv,
  output logic [1:0]              arb_grant,
  output logic [7:0]              arb_txn_cnt0,
  output logic [7:0]              arb_txn_cnt1
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t     state;
  logic [1:0] grant_r;
  logic       last_grant_r;
  logic       win1;
  logic       sel;
  logic       in_addr;
  logic       in_data;
  assign sel     = grant_r[1];
  assign in_addr = state == ADDR;
  assign in_data = state == DATA;
  // master 1 wins only when alone, or in round-robin when master 0 owned the last grant
  assign win1 = axi_mst1.arvalid && (!axi_mst0.arvalid || (FIXED_PRI == 0 && !last_grant_r));
  assign axi_slv.arvalid = in_addr & (sel ? axi_mst1.arvalid : axi_mst0.arvalid);
  assign axi_slv.arid    = sel ? axi_mst1.arid    : axi_mst0.arid;
  assign axi_slv.araddr  = sel ? axi_mst1.araddr  : axi_mst0.araddr;
  assign axi_slv.arlen   = sel ? axi_mst1.arlen   : axi_mst0.arlen;
  assign axi_slv.arsize  = sel ? axi_mst1.arsize  : axi_mst0.arsize;
  assign axi_slv.arburst = sel ? axi_mst1.arburst : axi_mst0.arburst;
  assign axi_slv.rready  = in_data & (sel ? axi_mst1.rready : axi_mst0.rready);
  assign axi_mst0.arready = in_addr & grant_r[0] & axi_slv.arready;
  assign axi_mst1.arready = in_addr & grant_r[1] & axi_slv.arready;
  assign axi_mst0.rvalid  = in_data & grant_r[0] & axi_slv.rvalid;
  assign axi_mst1.rvalid  = in_data & grant_r[1] & axi_slv.rvalid;
  assign axi_mst0.rdata = axi_slv.rdata;
  assign axi_mst1.rdata = axi_slv.rdata;
  assign axi_mst0.rresp = axi_slv.rresp;
  assign axi_mst1.rresp = axi_slv.rresp;
  assign axi_mst0.rlast = axi_slv.rlast;
  assign axi_mst1.rlast = axi_slv.rlast;
  // grant_r is cleared on return to IDLE, so it doubles as the idle-masked grant
  assign arb_grant = grant_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant_r      <= 2'b00;
      last_grant_r <= 1'b1;
      arb_txn_cnt0 <= 8'd0;
      arb_txn_cnt1 <= 8'd0;
    end else begin
      case (state)
        IDLE: if (enable && (axi_mst0.arvalid || axi_mst1.arvalid)) begin
          state   <= ADDR;
          grant_r <= {win1, !win1};
        end
        ADDR: if (axi_slv.arvalid && axi_slv.arready) begin
          state        <= DATA;
          last_grant_r <= sel;
        end
        DATA: if (axi_slv.rvalid && axi_slv.rready && axi_slv.rlast) begin
          state        <= IDLE;
          grant_r      <= 2'b00;
          arb_txn_cnt0 <= arb_txn_cnt0 + {7'd0, grant_r[0]};
          arb_txn_cnt1 <= arb_txn_cnt1 + {7'd0, grant_r[1]};
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// tb_easyaxi_rd_arb: directed bench for round-robin (u[0]) and fixed-priority (u[1]) arbiters
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif
`ifndef AXI_RESP_OKAY
`define AXI_RESP_OKAY 2'b00
`endif
`ifndef AXI_RESP_DECERR
`define AXI_RESP_DECERR 2'b11
`endif

module tb_easyaxi_rd_arb;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] en;
  logic [1:0]  m_arvalid [2];
  logic [1:0]  m_rready [2];
  logic [31:0] m_araddr [2][2];
  logic [7:0]  m_arlen [2][2];
  logic [1:0]  o_arready [2];
  logic [1:0]  o_rvalid [2];
  logic [1:0]  grant [2];
  logic [1:0]  o_rresp [2];
  logic [7:0]  cnt0 [2];
  logic [7:0]  cnt1 [2];
  logic [31:0] o_rdata [2];
  logic [31:0] o_rdata1 [2];
  logic [31:0] o_slv_araddr [2];
  logic        o_rlast [2];
  logic        o_slv_arvalid [2];
  logic        o_slv_rready [2];
  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    easyaxi_rd_arb_if m0();
    easyaxi_rd_arb_if m1();
    easyaxi_rd_arb_if s();
    easyaxi_rd_arb #(.FIXED_PRI(g)) dut (
      .clk(clk), .rst_n(rst_n), .enable(en[g]),
      .axi_mst0(m0), .axi_mst1(m1), .axi_slv(s),
      .arb_grant(grant[g]), .arb_txn_cnt0(cnt0[g]), .arb_txn_cnt1(cnt1[g])
    );
    assign m0.arvalid = m_arvalid[g][0];
    assign m0.arid    = 4'd0;
    assign m0.araddr  = m_araddr[g][0];
    assign m0.arlen   = m_arlen[g][0];
    assign m0.arsize  = 3'd2;
    assign m0.arburst = 2'd1;
    assign m0.rready  = m_rready[g][0];
    assign m1.arvalid = m_arvalid[g][1];
    assign m1.arid    = 4'd1;
    assign m1.araddr  = m_araddr[g][1];
    assign m1.arlen   = m_arlen[g][1];
    assign m1.arsize  = 3'd2;
    assign m1.arburst = 2'd1;
    assign m1.rready  = m_rready[g][1];
    assign o_arready[g]     = {m1.arready, m0.arready};
    assign o_rvalid[g]      = {m1.rvalid, m0.rvalid};
    assign o_rdata[g]       = m0.rdata;
    assign o_rdata1[g]      = m1.rdata;
    assign o_rresp[g]       = m0.rresp;
    assign o_rlast[g]       = m0.rlast;
    assign o_slv_arvalid[g] = s.arvalid;
    assign o_slv_rready[g]  = s.rready;
    assign o_slv_araddr[g]  = s.araddr;
    // slave: accepts one AR when free, returns arlen+1 beats tagged {id, addr[19:0], beat}
    logic busy;
    logic [7:0] beat, len_q;
    logic [31:0] addr_q;
    logic [3:0] id_q;
    assign s.arready = ~busy;
    assign s.rvalid  = busy;
    assign s.rdata   = {id_q, addr_q[19:0], beat};
    assign s.rresp   = (addr_q == 32'h4) ? `AXI_RESP_DECERR : `AXI_RESP_OKAY;
    assign s.rlast   = busy & (beat == len_q);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy <= 1'b0; beat <= 8'd0; len_q <= 8'd0; addr_q <= 32'd0; id_q <= 4'd0;
      end else if (!busy) begin
        if (s.arvalid) begin
          busy <= 1'b1; beat <= 8'd0; len_q <= s.arlen; addr_q <= s.araddr; id_q <= s.arid;
        end
      end else if (s.rready) begin
        beat <= beat + 8'd1;
        if (beat == len_q) busy <= 1'b0;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int d, input int m, input logic [31:0] addr, input logic [7:0] len,
                         input bit tog, input bit drop_en, output int beats, output logic [1:0] resp,
                         output int derr, output int viol, output bit to);
    bit ph, hs, fin;
    m_araddr[d][m] = addr;
    m_arlen[d][m] = len;
    m_arvalid[d][m] = 1'b1;
    beats = 0; derr = 0; viol = 0; to = 1'b1; ph = 1'b1; resp = 2'b00;
    for (int i = 0; i < 64; i++) begin
      m_rready[d][m] = tog ? ph : 1'b1;
      ph = ~ph;
      #1;
      hs = o_arready[d][m] & m_arvalid[d][m];
      fin = 1'b0;
      if (o_arready[d][1-m] | o_rvalid[d][1-m]) viol++;
      if (o_rvalid[d][m] & m_rready[d][m]) begin
        if (o_rdata[d] !== {4'(m), addr[19:0], 8'(beats)} || o_rdata1[d] !== o_rdata[d] ||
            o_rlast[d] !== (beats == int'(len))) derr++;
        resp = o_rresp[d];
        fin = o_rlast[d];
        beats++;
      end
      @(posedge clk);
      #1;
      if (hs) begin
        m_arvalid[d][m] = 1'b0;
        if (drop_en) en[d] = 1'b0;
      end
      if (fin) begin
        to = 1'b0;
        break;
      end
    end
    m_arvalid[d][m] = 1'b0;
    m_rready[d][m] = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en = 2'b11;
    for (int d = 0; d < 2; d++) begin
      m_arvalid[d] = 2'b11;
      m_rready[d] = 2'b11;
      m_araddr[d][0] = 32'h111; m_araddr[d][1] = 32'h222;
      m_arlen[d][0] = 8'd0; m_arlen[d][1] = 8'd0;
    end
    step;
    step;
    for (int d = 0; d < 2; d++) begin
      vec++;
      if ({grant[d], o_arready[d], o_rvalid[d], o_slv_arvalid[d], o_slv_rready[d]} !== 8'd0) begin
        errs++;
        $display("FAIL reset_outputs[%0d]: got %b want 00000000", d,
                 {grant[d], o_arready[d], o_rvalid[d], o_slv_arvalid[d], o_slv_rready[d]});
      end
      vec++;
      if ({cnt0[d], cnt1[d]} !== 16'd0) begin
        errs++;
        $display("FAIL reset_counters[%0d]: got %h want 0000", d, {cnt0[d], cnt1[d]});
      end
      vec++;
      if (o_slv_araddr[d] !== 32'h111) begin
        errs++;
        $display("FAIL reset_payload_mux[%0d]: got %h want 00000111", d, o_slv_araddr[d]);
      end
    end
    m_arvalid[0] = 2'b00;
    m_arvalid[1] = 2'b00;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_contention;
    m_araddr[0][0] = 32'h0; m_araddr[0][1] = 32'h0;
    m_arlen[0][0] = 8'd0; m_arlen[0][1] = 8'd0;
    m_arvalid[0] = 2'b11;
    #1;
    vec++;
    if ({grant[0], o_arready[0]} !== 4'b0000) begin
      errs++; $display("FAIL decision_cycle: got %b want 0000", {grant[0], o_arready[0]});
    end
    step; #1;
    vec++;
    if ({grant[0], o_arready[0], o_slv_arvalid[0]} !== 5'b01011) begin
      errs++; $display("FAIL m0_first_grant: got %b want 01011", {grant[0], o_arready[0], o_slv_arvalid[0]});
    end
    step;
    m_arvalid[0][0] = 1'b0;
    #1;
    vec++;
    if ({grant[0], o_rvalid[0], o_rlast[0], o_rdata[0]} !== {2'b01, 2'b01, 1'b1, 32'h0}) begin
      errs++; $display("FAIL m0_data: got %h want %h", {grant[0], o_rvalid[0], o_rlast[0], o_rdata[0]},
                       {2'b01, 2'b01, 1'b1, 32'h0});
    end
    step; #1;
    vec++;
    if ({grant[0], o_arready[0], cnt0[0], cnt1[0]} !== {2'b00, 2'b00, 8'd1, 8'd0}) begin
      errs++; $display("FAIL m0_done_idle: got %h want %h", {grant[0], o_arready[0], cnt0[0], cnt1[0]},
                       {2'b00, 2'b00, 8'd1, 8'd0});
    end
    step; #1;
    vec++;
    if ({grant[0], o_arready[0]} !== 4'b1010) begin
      errs++; $display("FAIL m1_next_grant: got %b want 1010", {grant[0], o_arready[0]});
    end
    step;
    m_arvalid[0][1] = 1'b0;
    #1;
    vec++;
    if ({grant[0], o_rvalid[0], o_rdata1[0]} !== {2'b10, 2'b10, 32'h1000_0000}) begin
      errs++; $display("FAIL m1_data: got %h want %h", {grant[0], o_rvalid[0], o_rdata1[0]},
                       {2'b10, 2'b10, 32'h1000_0000});
    end
    step; #1;
    vec++;
    if ({grant[0], cnt0[0], cnt1[0]} !== {2'b00, 8'd1, 8'd1}) begin
      errs++; $display("FAIL contention_counts: got %h want %h", {grant[0], cnt0[0], cnt1[0]}, {2'b00, 8'd1, 8'd1});
    end
  endtask

  task automatic test_burst;
    int beats, derr, viol, extra;
    logic [1:0] resp;
    bit to;
    run_txn(0, 1, 32'h100, 8'd3, 1'b1, 1'b0, beats, resp, derr, viol, to);
    vec++;
    if ({to, beats} !== {1'b0, 32'd4}) begin
      errs++; $display("FAIL burst_beats: got timeout=%0d beats=%0d want timeout=0 beats=4", to, beats);
    end
    vec++;
    if (derr !== 0) begin
      errs++; $display("FAIL burst_data_last: got %0d bad beats want 0", derr);
    end
    vec++;
    if (viol !== 0) begin
      errs++; $display("FAIL burst_m0_quiet: got %0d cycles with m0 arready/rvalid want 0", viol);
    end
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      if (o_rvalid[0] !== 2'b00) extra++;
      step;
    end
    vec++;
    if ({extra, cnt1[0]} !== {32'd0, 8'd2}) begin
      errs++; $display("FAIL burst_after: got extra=%0d cnt1=%0d want extra=0 cnt1=2", extra, cnt1[0]);
    end
  endtask

  task automatic test_decerr;
    int beats, derr, viol;
    logic [1:0] resp;
    bit to;
    run_txn(0, 0, 32'h4, 8'd0, 1'b0, 1'b0, beats, resp, derr, viol, to);
    vec++;
    if ({to, beats, resp} !== {1'b0, 32'd1, `AXI_RESP_DECERR}) begin
      errs++; $display("FAIL decerr_beat: got timeout=%0d beats=%0d resp=%b want 0 1 %b", to, beats, resp, `AXI_RESP_DECERR);
    end
    #1;
    vec++;
    if ({grant[0], o_slv_arvalid[0], o_slv_rready[0], cnt0[0], derr, viol} !== {2'b00, 1'b0, 1'b0, 8'd2, 32'd0, 32'd0}) begin
      errs++; $display("FAIL decerr_idle: got grant=%b arv=%b rrdy=%b cnt0=%0d derr=%0d viol=%0d want 00 0 0 2 0 0",
                       grant[0], o_slv_arvalid[0], o_slv_rready[0], cnt0[0], derr, viol);
    end
  endtask

  task automatic test_enable;
    int beats, derr, viol, leak;
    logic [1:0] resp;
    bit to;
    run_txn(0, 0, 32'h40, 8'd2, 1'b0, 1'b1, beats, resp, derr, viol, to);
    vec++;
    if ({to, beats, derr, viol, en[0], cnt0[0]} !== {1'b0, 32'd3, 32'd0, 32'd0, 1'b0, 8'd3}) begin
      errs++; $display("FAIL enable_burst: got to=%0d beats=%0d derr=%0d viol=%0d cnt0=%0d want 0 3 0 0 3",
                       to, beats, derr, viol, cnt0[0]);
    end
    m_araddr[0][1] = 32'h80;
    m_arlen[0][1] = 8'd0;
    m_arvalid[0][1] = 1'b1;
    leak = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (grant[0] !== 2'b00 || o_arready[0] !== 2'b00) leak++;
      step;
    end
    vec++;
    if (leak !== 0) begin
      errs++; $display("FAIL enable_blocks: got %0d granted cycles want 0", leak);
    end
    en[0] = 1'b1;
    step; #1;
    vec++;
    if (grant[0] !== 2'b10) begin
      errs++; $display("FAIL enable_resume: got %b want 10", grant[0]);
    end
    run_txn(0, 1, 32'h80, 8'd0, 1'b0, 1'b0, beats, resp, derr, viol, to);
    vec++;
    if ({to, beats, derr, cnt1[0]} !== {1'b0, 32'd1, 32'd0, 8'd3}) begin
      errs++; $display("FAIL enable_m1_txn: got to=%0d beats=%0d derr=%0d cnt1=%0d want 0 1 0 3", to, beats, derr, cnt1[0]);
    end
  endtask

  task automatic test_fixed_pri;
    int beats, derr, viol;
    logic [1:0] resp;
    bit to;
    m_araddr[1][1] = 32'h200;
    m_arlen[1][1] = 8'd0;
    m_arvalid[1][1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_txn(1, 0, 32'h300 + 32'(k), 8'd0, 1'b0, 1'b0, beats, resp, derr, viol, to);
      vec++;
      if ({to, beats, derr, viol} !== {1'b0, 32'd1, 32'd0, 32'd0}) begin
        errs++; $display("FAIL fixed_txn%0d: got to=%0d beats=%0d derr=%0d viol=%0d want 0 1 0 0", k, to, beats, derr, viol);
      end
    end
    m_arvalid[1][1] = 1'b0;
    vec++;
    if ({cnt0[1], cnt1[1]} !== {8'd3, 8'd0}) begin
      errs++; $display("FAIL fixed_counts: got cnt0=%0d cnt1=%0d want 3 0", cnt0[1], cnt1[1]);
    end
    step; #1;
    vec++;
    if (grant[1] !== 2'b00) begin
      errs++; $display("FAIL fixed_idle: got %b want 00", grant[1]);
    end
  endtask

  task automatic test_reset_mid;
    int beats, derr, viol;
    logic [1:0] resp;
    bit to;
    m_araddr[0][0] = 32'h8;
    m_arlen[0][0] = 8'd3;
    m_arvalid[0][0] = 1'b1;
    step;
    step;
    m_arvalid[0][0] = 1'b0;
    #1;
    vec++;
    if ({grant[0], o_rvalid[0]} !== 4'b0101) begin
      errs++; $display("FAIL midreset_pre: got %b want 0101", {grant[0], o_rvalid[0]});
    end
    step;
    rst_n = 1'b0;
    #1;
    vec++;
    if ({grant[0], o_arready[0], o_rvalid[0], o_slv_arvalid[0], o_slv_rready[0]} !== 8'd0) begin
      errs++; $display("FAIL midreset_outputs: got %b want 00000000",
                       {grant[0], o_arready[0], o_rvalid[0], o_slv_arvalid[0], o_slv_rready[0]});
    end
    vec++;
    if ({cnt0[0], cnt1[0], cnt0[1]} !== 24'd0) begin
      errs++; $display("FAIL midreset_counters: got %h want 000000", {cnt0[0], cnt1[0], cnt0[1]});
    end
    step;
    rst_n = 1'b1;
    step;
    run_txn(0, 1, 32'h10, 8'd0, 1'b0, 1'b0, beats, resp, derr, viol, to);
    vec++;
    if ({to, beats, derr, cnt0[0], cnt1[0]} !== {1'b0, 32'd1, 32'd0, 8'd0, 8'd1}) begin
      errs++; $display("FAIL post_reset_txn: got to=%0d beats=%0d derr=%0d cnt0=%0d cnt1=%0d want 0 1 0 0 1",
                       to, beats, derr, cnt0[0], cnt1[0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_contention;
    test_burst;
    test_decerr;
    test_enable;
    test_fixed_pri;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
